// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache controller and its helpers.
package cache_pkg;

  localparam int unsigned DEF_NUM_ENTRIES = 16;
  localparam int unsigned DEF_KEY_WIDTH   = 16;
  localparam int unsigned DEF_VALUE_WIDTH = 64;
  localparam int unsigned IDX_W           = $clog2(DEF_NUM_ENTRIES);

  typedef enum logic {
    OP_GET = 1'b0,
    OP_PUT = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/free_entry_finder.sv
// Combinational search for the lowest unused memory entry.
module free_entry_finder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] used_i,
  output logic [N-1:0] free_mask_o,
  output logic         found_o
);

  // Adding one ripples through the trailing ones and lands on the lowest zero.
  assign free_mask_o = ~used_i & (used_i + N'(1));
  assign found_o     = ~&used_i;

endmodule

// File: rtl/cache_controller.sv
// Request-side controller: scans the memory block for a key, then answers a GET
// or writes a PUT (overwrite on hit, first free entry on miss).
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int unsigned KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic [NUM_ENTRIES-1:0] mem_index,
  output logic                   mem_write_op,
  output logic                   mem_select_op,
  output logic [KEY_WIDTH-1:0]   mem_key_out,
  output logic [VALUE_WIDTH-1:0] mem_value_out,
  input  logic [KEY_WIDTH-1:0]   mem_key_in,
  input  logic [VALUE_WIDTH-1:0] mem_value_in,
  input  logic [NUM_ENTRIES-1:0] mem_used_entries
);

  localparam int unsigned CNT_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  ctrl_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  op_e                    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic                   rsp_valid_q, rsp_valid_d;
  status_e                rsp_status_q, rsp_status_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic [NUM_ENTRIES-1:0] mem_index_q, mem_index_d;
  logic                   mem_select_q, mem_select_d;
  logic                   mem_write_q, mem_write_d;
  logic [KEY_WIDTH-1:0]   mem_key_q, mem_key_d;
  logic [VALUE_WIDTH-1:0] mem_value_q, mem_value_d;

  logic [NUM_ENTRIES-1:0] free_mask_c;
  logic                   free_found_c;
  logic                   hit_c;
  logic                   last_c;

  free_entry_finder #(
    .N (NUM_ENTRIES)
  ) u_free (
    .used_i      (mem_used_entries),
    .free_mask_o (free_mask_c),
    .found_o     (free_found_c)
  );

  // Unused entries are excluded so stale keys can never match.
  assign hit_c  = mem_used_entries[cnt_q] && (mem_key_in == key_q);
  assign last_c = (cnt_q == CNT_W'(NUM_ENTRIES - 1));

  // Ready is a direct decode of IDLE so a request can land the cycle after a response.
  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_value     = rsp_value_q;
  assign mem_index     = mem_index_q;
  assign mem_write_op  = mem_write_q;
  assign mem_select_op = mem_select_q;
  assign mem_key_out   = mem_key_q;
  assign mem_value_out = mem_value_q;

  // Next-state and next-output decode; memory strobes are pulses by default.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    key_d        = key_q;
    value_d      = value_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_value_d  = rsp_value_q;
    mem_index_d  = '0;
    mem_select_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_key_d    = '0;
    mem_value_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d         = op_e'(req_op);
          key_d        = req_key;
          value_d      = req_value;
          cnt_d        = '0;
          rsp_status_d = ST_OK;
          rsp_value_d  = '0;
          mem_select_d = 1'b1;
          mem_index_d  = NUM_ENTRIES'(1);
          mem_key_d    = req_key;
          state_d      = S_SCAN;
        end
      end

      S_SCAN: begin
        if (hit_c) begin
          if (op_q == OP_GET) begin
            rsp_value_d  = mem_value_in;
            rsp_status_d = ST_OK;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else begin
            mem_write_d  = 1'b1;
            mem_index_d  = mem_index_q;
            mem_key_d    = key_q;
            mem_value_d  = value_q;
            rsp_status_d = ST_OK;
            state_d      = S_WRITE;
          end
        end else if (!last_c) begin
          cnt_d        = cnt_q + CNT_W'(1);
          mem_select_d = 1'b1;
          mem_index_d  = mem_index_q << 1;
          mem_key_d    = key_q;
        end else if (op_q == OP_GET) begin
          rsp_status_d = ST_MISS;
          rsp_value_d  = '0;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          // Allocation target is chosen here so the write strobe lands on the WRITE cycle.
          if (free_found_c) begin
            mem_write_d  = 1'b1;
            mem_index_d  = free_mask_c;
            mem_key_d    = key_q;
            mem_value_d  = value_q;
            rsp_status_d = ST_OK;
          end else begin
            rsp_status_d = ST_FULL;
          end
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_GET;
      key_q        <= '0;
      value_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_value_q  <= '0;
      mem_index_q  <= '0;
      mem_select_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_key_q    <= '0;
      mem_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      key_q        <= key_d;
      value_q      <= value_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_value_q  <= rsp_value_d;
      mem_index_q  <= mem_index_d;
      mem_select_q <= mem_select_d;
      mem_write_q  <= mem_write_d;
      mem_key_q    <= mem_key_d;
      mem_value_q  <= mem_value_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural memory block behind it.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned KW = 16;
  localparam int unsigned VW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [KW-1:0] req_key;
  logic [VW-1:0] req_value;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [VW-1:0] rsp_value;
  logic [N-1:0]  mem_index;
  logic          mem_write_op, mem_select_op;
  logic [KW-1:0] mem_key_out, mem_key_in;
  logic [VW-1:0] mem_value_out, mem_value_in;
  logic [N-1:0]  mem_used_entries;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_edge = 0;
  logic [N-1:0] wr_idx = '0;
  logic mon_en = 1'b0;

  cache_controller dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_key          (req_key),
    .req_value        (req_value),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_status       (rsp_status),
    .rsp_value        (rsp_value),
    .mem_index        (mem_index),
    .mem_write_op     (mem_write_op),
    .mem_select_op    (mem_select_op),
    .mem_key_out      (mem_key_out),
    .mem_value_out    (mem_value_out),
    .mem_key_in       (mem_key_in),
    .mem_value_in     (mem_value_in),
    .mem_used_entries (mem_used_entries)
  );

  always #5 clk = ~clk;

  // Memory model; reset plants key 0x9999 in every cell so unused stale keys are exercised.
  logic [KW-1:0] mkey [N];
  logic [VW-1:0] mval [N];
  logic [N-1:0]  used;

  always @(posedge clk) begin
    if (rst) begin
      used <= '0;
      for (int j = 0; j < N; j++) begin
        mkey[j] <= 16'h9999;
        mval[j] <= 64'hBAD0_BAD0;
      end
    end else if (mem_write_op) begin
      for (int j = 0; j < N; j++) begin
        if (mem_index[j]) begin
          mkey[j] <= mem_key_out;
          mval[j] <= mem_value_out;
          used[j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_key_in   = '0;
    mem_value_in = '0;
    for (int j = 0; j < N; j++) begin
      if (mem_index[j]) begin
        mem_key_in   = mkey[j];
        mem_value_in = mval[j];
      end
    end
  end

  assign mem_used_entries = used;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write recorder plus per-cycle strobe sanity.
  always @(posedge clk) begin
    if (mon_en) begin
      if (mem_write_op === 1'b1) begin
        wr_cnt++;
        wr_idx  = mem_index;
        wr_edge = cyc;
      end
      check("strobe_excl", 64'(mem_write_op & mem_select_op), 64'd0);
      if (!mem_write_op && !mem_select_op) check("idx_idle", 64'(mem_index), 64'd0);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                        output int e);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_value = v;
    tick();
    e         = cyc;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_key   = '0;
    req_value = '0;
  endtask

  task automatic wait_rsp(input int e, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        lat = cyc - e;
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input logic op, input logic [KW-1:0] k,
                     input logic [VW-1:0] v, input int exp_lat, input logic [1:0] exp_st,
                     input logic [VW-1:0] exp_val, output int e);
    int lat;
    do_req(op, k, v, e);
    wait_rsp(e, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_status"}, 64'(rsp_status), 64'(exp_st));
    check({tag, "_value"}, rsp_value, exp_val);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, lat, w0;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = '0; req_value = '0;
    rsp_ready = 1'b1;

    tick();
    mon_en = 1'b1;
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_rsp_value", rsp_value, 64'd0);
    check("rst_mem_index", 64'(mem_index), 64'd0);
    check("rst_strobes", 64'({mem_write_op, mem_select_op}), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_mem_key", 64'(mem_key_out), 64'd0);

    // Insert into an empty cache lands in entry 0 after the full scan.
    w0 = wr_cnt;
    txn("t1_put", 1'b1, 16'h1234, 64'hDEAD_BEEF, 17, 2'd0, 64'd0, e);
    check("t1_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("t1_wr_idx", 64'(wr_idx), 64'h0001);
    check("t1_wr_time", 64'(wr_edge - e), 64'd16);
    check("t1_used", 64'(used), 64'h0001);

    // Hit at entry 0; the first scan cycle selects entry 0 with the latched key.
    do_req(1'b0, 16'h1234, 64'd0, e);
    check("t2_select", 64'(mem_select_op), 64'd1);
    check("t2_index", 64'(mem_index), 64'h0001);
    check("t2_key_out", 64'(mem_key_out), 64'h1234);
    wait_rsp(e, lat);
    check("t2_lat", 64'(lat), 64'd1);
    check("t2_status", 64'(rsp_status), 64'd0);
    check("t2_value", rsp_value, 64'hDEAD_BEEF);
    tick();

    // Overwrite an existing key in place.
    w0 = wr_cnt;
    txn("t3_put", 1'b1, 16'h1234, 64'h55, 2, 2'd0, 64'd0, e);
    check("t3_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("t3_wr_idx", 64'(wr_idx), 64'h0001);
    check("t3_wr_time", 64'(wr_edge - e), 64'd1);
    check("t3_used", 64'(used), 64'h0001);
    txn("t3_get", 1'b0, 16'h1234, 64'd0, 1, 2'd0, 64'h55, e);

    // Absent key misses even though unused cells hold a stale 0x9999.
    w0 = wr_cnt;
    txn("t4_miss", 1'b0, 16'h9999, 64'd0, 16, 2'd1, 64'd0, e);
    check("t4_no_write", 64'(wr_cnt - w0), 64'd0);

    // Fill the remaining entries in order, then overflow.
    for (int j = 1; j < 16; j++) begin
      txn("t5_fill", 1'b1, KW'(32'h1000 + j), 64'hC0DE_0000_0000_0000 | 64'(j), 17, 2'd0,
          64'd0, e);
      check("t5_fill_idx", 64'(wr_idx), 64'(N'(1) << j));
    end
    check("t5_used_full", 64'(used), 64'hFFFF);
    w0 = wr_cnt;
    txn("t5_full", 1'b1, 16'hAAAA, 64'h1, 17, 2'd2, 64'd0, e);
    check("t5_full_no_write", 64'(wr_cnt - w0), 64'd0);
    check("t5_full_used", 64'(used), 64'hFFFF);
    txn("t5_get5", 1'b0, 16'h1005, 64'd0, 6, 2'd0, 64'hC0DE_0000_0000_0005, e);
    w0 = wr_cnt;
    txn("t5_upd15", 1'b1, 16'h100F, 64'h77, 17, 2'd0, 64'd0, e);
    check("t5_upd_cnt", 64'(wr_cnt - w0), 64'd1);
    check("t5_upd_idx", 64'(wr_idx), 64'h8000);
    check("t5_upd_time", 64'(wr_edge - e), 64'd16);
    txn("t5_get15", 1'b0, 16'h100F, 64'd0, 16, 2'd0, 64'h77, e);
    txn("t5_get_absent", 1'b0, 16'hAAAA, 64'd0, 16, 2'd1, 64'd0, e);

    // Response back-pressure keeps the response frozen.
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h1234, 64'd0, e);
    wait_rsp(e, lat);
    check("t6_bp_lat", 64'(lat), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_bp_valid", 64'(rsp_valid), 64'd1);
      check("t6_bp_status", 64'(rsp_status), 64'd0);
      check("t6_bp_value", rsp_value, 64'h55);
      check("t6_bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("t6_rel_valid", 64'(rsp_valid), 64'd0);
    check("t6_rel_ready", 64'(req_ready), 64'd1);

    // Reset partway through a PUT scan must abandon it.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t6_mem_cleared", 64'(used), 64'd0);
    w0 = wr_cnt;
    do_req(1'b1, 16'hBEEF, 64'h1, e);
    for (int k = 0; k < 5; k++) tick();
    check("t6_mid_scan", 64'(mem_select_op), 64'd1);
    rst = 1'b1;
    tick();
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    check("t6_rst_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_select", 64'(mem_select_op), 64'd0);
    check("t6_rst_index", 64'(mem_index), 64'd0);
    rst = 1'b0;
    tick();
    check("t6_post_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 20; k++) tick();
    check("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    check("t6_no_rsp", 64'(rsp_valid), 64'd0);
    check("t6_used_empty", 64'(used), 64'd0);

    // Normal operation resumes after the aborted request.
    txn("t7_miss", 1'b0, 16'h9999, 64'd0, 16, 2'd1, 64'd0, e);
    txn("t7_put", 1'b1, 16'h1234, 64'h99, 17, 2'd0, 64'd0, e);
    check("t7_wr_idx", 64'(wr_idx), 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
